// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a register-file address window and streams each word out
// Reads through the asynchronous read port one word at a time, holding each until accepted downstream.
module regfile_dump_reader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] Base_Addr,
    input  logic [ADDR_WIDTH:0]   Count,
    output logic [ADDR_WIDTH-1:0] Rd_Addr,
    input  logic [DATA_WIDTH-1:0] Rd_Data,
    output logic [DATA_WIDTH-1:0] Out_Data,
    output logic [ADDR_WIDTH-1:0] Out_Addr,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic                  Busy,
    output logic                  Done
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q,   rd_addr_d;
    logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
    logic [ADDR_WIDTH-1:0]   out_addr_q,  out_addr_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q,      busy_d;
    logic                    done_q,      done_d;
    logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
    logic [ADDR_WIDTH:0]     count_clamped;

    assign count_clamped = (Count > DEPTH_CNT) ? DEPTH_CNT : Count;

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        remaining_d = remaining_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    rd_addr_d   = Base_Addr;
                    remaining_d = count_clamped;
                    state_d     = (count_clamped == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                out_data_d  = Rd_Data;
                out_addr_d  = rd_addr_q;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_valid_q && Out_Ready) begin
                    out_valid_d = 1'b0;
                    remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
                    if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        // Explicit wrap keeps non-power-of-two depths correct.
                        rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_WIDTH'(1);
                        state_d   = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            remaining_q <= remaining_d;
        end
    end

    assign Rd_Addr   = rd_addr_q;
    assign Out_Data  = out_data_q;
    assign Out_Addr  = out_addr_q;
    assign Out_Valid = out_valid_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule
